// File: rtl/bist_4in_tester_if.sv
// Bus between the start/compare controller and the bist_4in_tester engine.
// The engine uses the slave modport; the controller/unit-under-test side uses master.
interface bist_4in_tester_if;
  logic        start;
  logic        f_in;
  logic        a;
  logic        b;
  logic        c;
  logic        d;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] observed;
  logic [4:0]  fail_count;
  logic [3:0]  first_fail;
  logic        fail_valid;

  modport master (
    output start, f_in,
    input  a, b, c, d, busy, done, pass, observed, fail_count, first_fail, fail_valid
  );

  modport slave (
    input  start, f_in,
    output a, b, c, d, busy, done, pass, observed, fail_count, first_fail, fail_valid
  );
endinterface

// File: rtl/bist_4in_tester.sv
// Exhaustive self-test engine for a 4-input combinational function block.
// Optional macro BIST_STOP_ON_FAIL_EN ends the run at the first mismatching vector.
module bist_4in_tester #(
  parameter logic [15:0] EXPECTED = 16'h0000,
  parameter logic [3:0]  SETTLE   = 4'd2
) (
  input logic              clock,
  input logic              reset,
  bist_4in_tester_if.slave bus
);

  typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;

  state_t      state_r, state_s;
  logic [3:0]  idx_r, idx_s;
  logic [3:0]  wcnt_r, wcnt_s;
  logic [3:0]  vec_r, vec_s;
  logic [15:0] observed_r, observed_s;
  logic [4:0]  fail_count_r, fail_count_s;
  logic [3:0]  first_fail_r, first_fail_s;
  logic        fail_valid_r, fail_valid_s;
  logic        busy_r, done_r, pass_r;
  logic        mismatch_s;
  logic        last_s;

  assign mismatch_s = (bus.f_in != EXPECTED[idx_r]);

  // Next-state and result update logic.
  always_comb begin
    state_s      = state_r;
    idx_s        = idx_r;
    wcnt_s       = wcnt_r;
    vec_s        = vec_r;
    observed_s   = observed_r;
    fail_count_s = fail_count_r;
    first_fail_s = first_fail_r;
    fail_valid_s = fail_valid_r;
    last_s       = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (bus.start) begin
          state_s      = APPLY;
          idx_s        = 4'd0;
          wcnt_s       = 4'd0;
          vec_s        = 4'd0;
          observed_s   = 16'h0000;
          fail_count_s = 5'd0;
          first_fail_s = 4'd0;
          fail_valid_s = 1'b0;
        end else begin
          state_s = state_r;
        end
      end
      APPLY: begin
        wcnt_s = wcnt_r + 4'd1;
        if (wcnt_r == SETTLE - 4'd1) begin
          state_s = SAMPLE;
        end else begin
          state_s = APPLY;
        end
      end
      SAMPLE: begin
        observed_s[idx_r] = bus.f_in;
        if (mismatch_s) begin
          fail_count_s = fail_count_r + 5'd1;
          if (!fail_valid_r) begin
            first_fail_s = idx_r;
            fail_valid_s = 1'b1;
          end else begin
            first_fail_s = first_fail_r;
          end
        end else begin
          fail_count_s = fail_count_r;
        end
`ifdef BIST_STOP_ON_FAIL_EN
        last_s = (idx_r == 4'd15) || mismatch_s;
`else
        last_s = (idx_r == 4'd15);
`endif
        if (last_s) begin
          state_s = DONE;
        end else begin
          state_s = APPLY;
          idx_s   = idx_r + 4'd1;
          vec_s   = idx_r + 4'd1;
          wcnt_s  = 4'd0;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, result and status registers; reset wins over start.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= IDLE;
      idx_r        <= 4'd0;
      wcnt_r       <= 4'd0;
      vec_r        <= 4'd0;
      observed_r   <= 16'h0000;
      fail_count_r <= 5'd0;
      first_fail_r <= 4'd0;
      fail_valid_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      pass_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      idx_r        <= idx_s;
      wcnt_r       <= wcnt_s;
      vec_r        <= vec_s;
      observed_r   <= observed_s;
      fail_count_r <= fail_count_s;
      first_fail_r <= first_fail_s;
      fail_valid_r <= fail_valid_s;
      busy_r       <= (state_s == APPLY) || (state_s == SAMPLE);
      done_r       <= (state_s == DONE);
      pass_r       <= (state_s == DONE) && (fail_count_s == 5'd0);
    end
  end

  assign bus.a          = vec_r[3];
  assign bus.b          = vec_r[2];
  assign bus.c          = vec_r[1];
  assign bus.d          = vec_r[0];
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.pass       = pass_r;
  assign bus.observed   = observed_r;
  assign bus.fail_count = fail_count_r;
  assign bus.first_fail = first_fail_r;
  assign bus.fail_valid = fail_valid_r;

endmodule
